// File: rtl/spi_frame_master.sv
// SPI frame master: serializes 10-bit command words onto MOSI inside an SS_n frame
// and, for read-data commands, captures the byte the slave returns on MISO.
module spi_frame_master #(
    parameter int LEAD_CYCLES = 2,
    parameter int RD_TURN     = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TURN,
        RECV,
        GAP
    } state_t;

    localparam logic [3:0] LEAD_LAST  = 4'(LEAD_CYCLES - 1);
    localparam logic [3:0] TURN_LAST  = 4'((RD_TURN > 0) ? RD_TURN - 1 : 0);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] SHIFT_LAST = 4'd9;
    localparam logic [3:0] RECV_LAST  = 4'd7;

    state_t     state;
    logic [3:0] cnt;
    logic [8:0] tx_shift;   // cmd[9] goes straight to MOSI at accept time
    logic       is_read;
    logic [6:0] rx_shift;

    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            tx_shift  <= '0;
            is_read   <= 1'b0;
            rx_shift  <= '0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tx_shift  <= cmd_data[8:0];
                        is_read   <= (cmd_data[9:8] == 2'b11);
                        state     <= LEAD;
                        cnt       <= '0;
                        SS_n      <= 1'b0;
                        MOSI      <= cmd_data[9];
                        busy      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                LEAD: begin
                    if (cnt == LEAD_LAST) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SHIFT: begin
                    if (cnt == SHIFT_LAST) begin
                        cnt  <= '0;
                        MOSI <= 1'b0;
                        if (!is_read) begin
                            state <= GAP;
                            SS_n  <= 1'b1;
                        end else if (RD_TURN == 0) begin
                            state <= RECV;
                        end else begin
                            state <= TURN;
                        end
                    end else begin
                        cnt      <= cnt + 4'd1;
                        MOSI     <= tx_shift[8];
                        tx_shift <= {tx_shift[7:0], 1'b0};
                    end
                end
                TURN: begin
                    if (cnt == TURN_LAST) begin
                        state <= RECV;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RECV: begin
                    // rsp_data only changes once the whole byte is in, so it
                    // stays stable between completed reads.
                    rx_shift <= {rx_shift[5:0], MISO};
                    if (cnt == RECV_LAST) begin
                        rsp_data  <= {rx_shift, MISO};
                        rsp_valid <= 1'b1;
                        state     <= GAP;
                        cnt       <= '0;
                        SS_n      <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a frame-plan reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_frame_master;

    localparam int LEAD_CYCLES = 2;
    localparam int RD_TURN     = 2;
    localparam int GAP_CYCLES  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_data = '0;
    logic       MISO = 1'b0;
    logic       cmd_ready, rsp_valid, busy, SS_n, MOSI;
    logic [7:0] rsp_data;

    always #5 clk = ~clk;

    spi_frame_master #(
        .LEAD_CYCLES(LEAD_CYCLES),
        .RD_TURN    (RD_TURN),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .busy     (busy),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: a per-cycle plan of the frame ----------------
    typedef struct {
        logic ss_n;
        logic mosi;
        bit   sample;   // MISO is captured at the edge ending this cycle
        bit   pulse;    // rsp_valid expected in this cycle
    } step_t;

    step_t      plan[$];
    logic       m_ready = 1'b0;
    logic [7:0] m_rsp   = '0;
    logic [7:0] m_rx    = '0;

    function automatic step_t mk(input logic ss, input logic mo, input bit smp, input bit pl);
        step_t s;
        s.ss_n = ss; s.mosi = mo; s.sample = smp; s.pulse = pl;
        return s;
    endfunction

    function automatic void build_frame(input logic [9:0] d);
        bit rd;
        rd = (d[9:8] == 2'b11);
        for (int i = 0; i < LEAD_CYCLES; i++) plan.push_back(mk(1'b0, d[9], 0, 0));
        for (int i = 9; i >= 0; i--)         plan.push_back(mk(1'b0, d[i], 0, 0));
        if (rd) begin
            for (int i = 0; i < RD_TURN; i++) plan.push_back(mk(1'b0, 1'b0, 0, 0));
            for (int i = 0; i < 8; i++)       plan.push_back(mk(1'b0, 1'b0, 1, 0));
        end
        for (int i = 0; i < GAP_CYCLES; i++) plan.push_back(mk(1'b1, 1'b0, 0, rd && i == 0));
    endfunction

    function automatic void model_step(input logic r, input logic v, input logic [9:0] d, input logic mi);
        step_t cur;
        if (r) begin
            plan.delete();
            m_ready = 1'b0;
            m_rsp   = '0;
            m_rx    = '0;
        end else if (plan.size() == 0) begin
            if (m_ready && v) begin
                build_frame(d);
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
        end else begin
            cur = plan.pop_front();
            if (cur.sample) m_rx = {m_rx[6:0], mi};
            if (plan.size() == 0) m_ready = 1'b1;
            else if (plan[0].pulse) m_rsp = m_rx;
        end
    endfunction

    logic e_ss, e_mosi, e_busy, e_ready, e_rv;

    always @(posedge clk) begin
        model_step(rst, cmd_valid, cmd_data, MISO);
        if (plan.size() > 0) begin
            e_ss = plan[0].ss_n; e_mosi = plan[0].mosi; e_busy = 1'b1;
            e_ready = 1'b0; e_rv = plan[0].pulse;
        end else begin
            e_ss = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_ready = m_ready; e_rv = 1'b0;
        end
        #1;
        check("ss_n", SS_n, e_ss);
        check("mosi", MOSI, e_mosi);
        check("busy", busy, e_busy);
        check("cmd_ready", cmd_ready, e_ready);
        check("rsp_valid", rsp_valid, e_rv);
        check("rsp_data", rsp_data, m_rsp);
    end

    // ---------------- slave model: drives MISO, byte from 15th low cycle ----------------
    bit         fixed_byte = 1'b0;
    logic [7:0] slv_byte   = 8'hC3;
    int         slv_cnt    = 0;

    always @(negedge clk) begin
        if (SS_n) begin
            slv_cnt = 0;
            if (!fixed_byte) slv_byte = 8'($urandom);
            MISO = 1'($urandom_range(0, 1));
        end else begin
            slv_cnt++;
            if (slv_cnt >= 15 && slv_cnt <= 22) MISO = slv_byte[22 - slv_cnt];
            else MISO = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- line monitor ----------------
    int          low_run = 0, high_run = 0, last_low = 0, last_high = 0;
    int          pulses = 0, ready_in_frame = 0;
    logic [31:0] frame_bits = '0, last_bits = '0, prev_bits = '0;
    logic [7:0]  last_rsp = '0;
    logic        prev_ss = 1'b1;

    always @(negedge clk) begin
        if (!SS_n) begin
            if (prev_ss) begin
                last_high  = high_run;
                low_run    = 0;
                frame_bits = '0;
            end
            low_run++;
            frame_bits = {frame_bits[30:0], MOSI};
            if (cmd_ready) ready_in_frame++;
        end else begin
            if (!prev_ss) begin
                last_low  = low_run;
                prev_bits = last_bits;
                last_bits = frame_bits;
                high_run  = 0;
            end
            high_run++;
        end
        if (rsp_valid) begin
            pulses++;
            last_rsp = rsp_data;
        end
        prev_ss = SS_n;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [9:0] d, input bit drop);
        cmd_valid = 1'b1;
        cmd_data  = d;
        for (int k = 0; k < 200; k++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        check("accept", cmd_ready, 1'b1);
        @(negedge clk);
        if (drop) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("wait_idle", busy, 1'b0);
        #1;
    endtask

    int  p0, r0;
    bit  keep;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ss_n", SS_n, 1'b1);
        check("rst_mosi", MOSI, 1'b0);
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1'b1);
        check("ss_after_rst", SS_n, 1'b1);

        // write address
        p0 = pulses; r0 = ready_in_frame;
        send(10'b00_1010_0101, 1);
        wait_idle();
        check("wr_len", last_low, 12);
        check("wr_bits", last_bits, 32'h0A5);
        check("wr_ready_low", ready_in_frame - r0, 0);
        check("wr_no_rsp", pulses - p0, 0);

        // read data, slave returns C3
        fixed_byte = 1'b1; slv_byte = 8'hC3;
        p0 = pulses;
        send(10'b11_0000_0000, 1);
        wait_idle();
        check("rd_len", last_low, 22);
        check("rd_bits", last_bits, 32'h3C0000);
        check("rd_pulses", pulses - p0, 1);
        check("rd_byte", last_rsp, 8'hC3);
        check("rd_hold", rsp_data, 8'hC3);

        // back-to-back with cmd_valid held high
        send(10'h155, 0);
        cmd_data = 10'h0AA;
        send(10'h0AA, 1);
        wait_idle();
        check("b2b_gap", last_high, 3);
        check("b2b_first", prev_bits, 32'h155);
        check("b2b_second", last_bits, 32'h0AA);
        check("b2b_len", last_low, 12);

        // reset in the 5th RECV cycle
        slv_byte = 8'hA5;
        p0 = pulses;
        send(10'h3FF, 1);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ss_n", SS_n, 1'b1);
        check("abort_rsp_data", rsp_data, 8'h00);
        check("abort_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("abort_no_rsp", pulses - p0, 0);
        fixed_byte = 1'b0;

        // stall: command offered during GAP, data changed before and after accept
        send(10'h0F0, 1);
        for (int k = 0; k < 100; k++) begin
            if (SS_n) break;
            @(negedge clk);
        end
        cmd_valid = 1'b1;
        cmd_data  = 10'h123;
        @(negedge clk);
        check("stall_ready", cmd_ready, 1'b0);
        send(10'h2C6, 0);
        cmd_data  = 10'h3FF;
        cmd_valid = 1'b0;
        wait_idle();
        check("stall_bits", last_bits, 32'hEC6);

        // randomized traffic, occasional reset mid-frame
        keep = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!keep) begin
                cmd_valid = 1'b0;
                cmd_data  = 10'($urandom);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            keep = 1'($urandom_range(0, 1));
            send(10'($urandom), !keep);
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(0, 24)) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- Upstream SPI master that drives the team's SPI slave/RAM link.
- Accepts 10-bit command words (code[9:8] + payload[7:0]) over a valid/ready handshake and serializes each as one SS_n-framed transfer on MOSI.
- For read-data commands (code 2'b11) it also captures the 8-bit byte returned on MISO and presents it on a response port.
- Clocked synchronously with the slave (SCLK = clk); there is no separate serial clock.

Parameters:
- LEAD_CYCLES, 2, cycles SS_n is low with MOSI = cmd[9] before the first shifted bit (slave command-check time); legal 1..7.
- RD_TURN, 2, turnaround cycles after the 10th bit of a 2'b11 command before MISO sampling starts; legal 0..7.
- GAP_CYCLES, 2, minimum cycles SS_n is held high between frames; legal 1..7.

Ports:
- clk, in, 1, single system clock; all logic on rising edge.
- rst, in, 1, synchronous active-high reset.
- cmd_valid, in, 1, command word available.
- cmd_ready, out, 1, block can accept a command this cycle.
- cmd_data, in, 10, [9:8] code (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- rsp_valid, out, 1, one-cycle pulse: rsp_data holds a read byte.
- rsp_data, out, 8, last byte captured from MISO.
- busy, out, 1, high from handshake until return to IDLE.
- SS_n, out, 1, slave select, active low.
- MOSI, out, 1, serial data to slave, MSB first.
- MISO, in, 1, serial data from slave, MSB first.

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset values: SS_n=1, MOSI=0, cmd_ready=0, rsp_valid=0, rsp_data=8'h00, busy=0, state=IDLE, all counters 0.
- cmd_ready=1 only in IDLE with rst low. It rises the cycle after rst deasserts.
- Handshake: cmd_valid & cmd_ready at edge E0 latches cmd_data into a shift register. Later changes to cmd_data are ignored.
- All outputs are registered.
- States and transitions:
  - IDLE: SS_n=1, MOSI=0. On handshake go to LEAD.
  - LEAD: SS_n=0, MOSI=cmd[9] for LEAD_CYCLES cycles. Then go to SHIFT.
  - SHIFT: SS_n=0, MOSI=cmd[9-i] for i=0..9, one bit per cycle. After bit 0: if code==2'b11 go to TURN (or RECV if RD_TURN==0), else go to GAP.
  - TURN: SS_n=0, MOSI=0 for RD_TURN cycles. Then go to RECV.
  - RECV: SS_n=0, MOSI=0. Sample MISO on 8 consecutive edges into rsp_data[7-j], j=0..7. Then go to GAP.
  - GAP: SS_n=1, MOSI=0 for GAP_CYCLES cycles. Then go to IDLE.
- Frame length (SS_n low, defaults): 12 cycles for codes 00/01/10; 22 cycles for code 11.
- rsp_valid: one-cycle pulse in the first GAP cycle after the 8th MISO sample. rsp_data is stable from that cycle until the next read completes.
- busy=1 in every state except IDLE.
- Counters: one 4-bit counter shared by LEAD/SHIFT/TURN/RECV/GAP, cleared on each state change. It must never wrap inside a state.
- Back-to-back commands: cmd_valid held high produces frames separated by exactly GAP_CYCLES SS_n-high cycles plus one IDLE cycle.
- Reset mid-frame: the next edge forces SS_n=1 and state IDLE. The frame is aborted, no rsp_valid is produced, and rsp_data is cleared.
- MISO is ignored outside RECV.

Test Plan:
- Reset release: assert rst for 3 cycles, then release -> SS_n=1, MOSI=0, rsp_valid=0 throughout; cmd_ready=1 on the first cycle after release.
- Write address: cmd_data=10'b00_1010_0101 -> SS_n low exactly 12 cycles; MOSI = 0,0 (lead), then 0,0,1,0,1,0,0,1,0,1; then 2 cycles SS_n=1; cmd_ready=0 for the whole transfer; no rsp_valid.
- Read data: cmd_data=10'b11_0000_0000 with a slave model returning 8'hC3 on MISO from the 15th low cycle -> SS_n low 22 cycles; rsp_valid one pulse with rsp_data=8'hC3.
- Back-to-back: cmd_valid held high with 10'h155 then 10'h0AA -> second SS_n fall occurs exactly 3 cycles after the first SS_n rise; both bit streams are correct.
- Reset mid-read: assert rst at the 5th RECV cycle -> next edge SS_n=1, rsp_data=0; no rsp_valid ever pulses.
- Stall: cmd_valid asserted during GAP -> not accepted until IDLE; cmd_data change before acceptance is reflected on MOSI, change after acceptance is not.
